// File: rtl/msb_codec_pkg.sv
// Shared definitions for the MSB index codec: decoder state encoding, default width,
// and one-hot / thermometer helpers used on both the encoder and decoder side.
package msb_codec_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int DEF_W  = 8;
    localparam int DEF_IW = $clog2(DEF_W);

    function automatic logic [DEF_W-1:0] onehot(input logic [DEF_IW-1:0] idx);
        return DEF_W'(1) << idx;
    endfunction

    // Computed one bit wider so that idx = DEF_W-1 yields all ones after truncation.
    function automatic logic [DEF_W-1:0] therm(input logic [DEF_IW-1:0] idx);
        logic [DEF_W:0] t;
        t = ((DEF_W+1)'(2) << idx) - (DEF_W+1)'(1);
        return t[DEF_W-1:0];
    endfunction

endpackage

// File: rtl/msb_index_decoder_idx_to_therm.sv
// Combinational index expander: produces the one-hot and thermometer
// (bits 0..idx set) vectors for a bit index.
module idx_to_therm #(
    parameter int W  = 8,
    parameter int IW = $clog2(W)
) (
    input  logic [IW-1:0] idx,
    output logic [W-1:0]  idx_onehot,
    output logic [W-1:0]  idx_therm
);

    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        assign idx_onehot[gi] = (idx == IW'(gi));
        assign idx_therm[gi]  = (IW'(gi) <= idx);
    end

endmodule

// File: rtl/msb_index_decoder.sv
// Rebuilds W-bit words from a stream of bit indices: each frame closed by idx_last
// is OR-accumulated, then held with a thermometer mask and index count until taken.
module msb_index_decoder
    import msb_codec_pkg::*;
#(
    parameter int W = DEF_W,
    localparam int IW = $clog2(W)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [IW-1:0] idx,
    input  logic          idx_valid,
    input  logic          idx_last,
    output logic          idx_ready,
    input  logic          flush,
    output logic [W-1:0]  word,
    output logic [W-1:0]  word_mask,
    output logic [IW:0]   word_count,
    output logic          word_valid,
    input  logic          word_ready
);

    localparam logic [IW:0] CNT_MAX = (IW+1)'(W);

    state_t        state_reg, state_next;
    logic [W-1:0]  acc_reg, acc_next;
    logic [IW-1:0] max_reg, max_next;
    logic          has_any_reg, has_any_next;
    logic [IW:0]   count_reg, count_next;
    logic [W-1:0]  word_reg, word_next;
    logic [W-1:0]  mask_reg, mask_next;
    logic [IW:0]   wcount_reg, wcount_next;

    logic [IW-1:0] max_new;
    logic [IW:0]   count_inc;
    logic [W-1:0]  idx_onehot;
    logic [W-1:0]  idx_therm_unused;
    logic [W-1:0]  max_onehot_unused;
    logic [W-1:0]  max_therm;

    assign max_new   = (has_any_reg && (max_reg > idx)) ? max_reg : idx;
    assign count_inc = (count_reg == CNT_MAX) ? CNT_MAX : count_reg + 1'b1;

    idx_to_therm #(.W(W), .IW(IW)) u_idx_exp (
        .idx        (idx),
        .idx_onehot (idx_onehot),
        .idx_therm  (idx_therm_unused)
    );

    // The mask follows the running maximum including the index being accepted now.
    idx_to_therm #(.W(W), .IW(IW)) u_max_exp (
        .idx        (max_new),
        .idx_onehot (max_onehot_unused),
        .idx_therm  (max_therm)
    );

    assign idx_ready  = (state_reg == ACCUM) && !flush;
    assign word_valid = (state_reg == HOLD);
    assign word       = word_reg;
    assign word_mask  = mask_reg;
    assign word_count = wcount_reg;

    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        max_next     = max_reg;
        has_any_next = has_any_reg;
        count_next   = count_reg;
        word_next    = word_reg;
        mask_next    = mask_reg;
        wcount_next  = wcount_reg;
        case (state_reg)
            ACCUM: begin
                if (flush) begin
                    acc_next     = '0;
                    has_any_next = 1'b0;
                    count_next   = '0;
                end else if (idx_valid) begin
                    if (idx_last) begin
                        word_next    = acc_reg | idx_onehot;
                        mask_next    = max_therm;
                        wcount_next  = count_inc;
                        state_next   = HOLD;
                        acc_next     = '0;
                        has_any_next = 1'b0;
                        count_next   = '0;
                    end else begin
                        acc_next     = acc_reg | idx_onehot;
                        max_next     = max_new;
                        has_any_next = 1'b1;
                        count_next   = count_inc;
                    end
                end
            end
            HOLD: begin
                if (word_ready) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= ACCUM;
            acc_reg     <= '0;
            max_reg     <= '0;
            has_any_reg <= 1'b0;
            count_reg   <= '0;
            word_reg    <= '0;
            mask_reg    <= '0;
            wcount_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            max_reg     <= max_next;
            has_any_reg <= has_any_next;
            count_reg   <= count_next;
            word_reg    <= word_next;
            mask_reg    <= mask_next;
            wcount_reg  <= wcount_next;
        end
    end

endmodule
